// File: rtl/ctrl_multi.sv
// rtl/ctrl_multi.sv - UART command parser dispatching to N_UNITS MAC units with result readout
// Parses address/opcode/operand bytes, sequences stall/accumulate/readout, keeps sticky error status.
module ctrl_multi #(
  parameter int N_UNITS    = 4,
  parameter int DATA_BYTES = 4,
  parameter int RES_BYTES  = 16,
  parameter int STALL_CYC  = 17,
  parameter int ACC_CYC    = 128,
  parameter int TIMEOUT    = 1023,
  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
  localparam int SW = $clog2(RES_BYTES)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [7:0]    data_in,
  input  logic          in,
  input  logic          busy,
  output logic          get,
  output logic          send,
  output logic [UW-1:0] unit,
  output logic          clear,
  output logic          acc,
  output logic [SW-1:0] sel,
  output logic          out,
  output logic [7:0]    status
);

  localparam int DW   = $clog2(DATA_BYTES + 1);
  localparam int CMAX = (STALL_CYC > ACC_CYC) ? STALL_CYC : ACC_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(TIMEOUT + 2);

  localparam logic [8:0]    N_UNITS_W  = 9'(N_UNITS);
  localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_CYC - 2);
  localparam logic [CW-1:0] ACC_LAST   = CW'(ACC_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(RES_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, OPCODE, DECODE, DATA, STALL, ACC, SEND
  } state_t;

  state_t        state, state_d;
  logic [7:0]    op_q;
  logic          discard_q;
  logic [UW-1:0] unit_q;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] sel_q;
  logic          out_q;
  logic          send_data_q;
  logic          tmo_q, bad_addr_q, bad_op_q;

  logic send_dec, clr_sticky, set_bad_op, set_bad_addr, set_tmo, load_unit;
  logic addr_bad, op_legal, timed_out, data_last_byte;

  assign addr_bad       = ({1'b0, data_in} >= N_UNITS_W);
  assign op_legal       = (op_q[7:3] == 5'd0);
  assign timed_out      = ((state == OPCODE) || (state == DATA)) && !in && (idle_cnt >= IDLE_LAST);
  assign data_last_byte = (state == DATA) && in && (dcnt == DATA_LAST);

  always_ff @(posedge clk) begin
    if (!nRst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    send_dec     = 1'b0;
    clear        = 1'b0;
    acc          = 1'b0;
    out          = 1'b0;
    clr_sticky   = 1'b0;
    set_bad_op   = 1'b0;
    set_bad_addr = 1'b0;
    set_tmo      = 1'b0;
    load_unit    = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_d      = OPCODE;
          set_bad_addr = addr_bad;
          load_unit    = !addr_bad;
        end
      end
      OPCODE: begin
        if (in) begin
          state_d = DECODE;
        end else if (timed_out) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (!op_legal) begin
          set_bad_op = 1'b1;
        end else begin
          // A discarded command (bad address) is fully parsed but has no side effects.
          case (op_q[2:0])
            3'd0, 3'd1: state_d = DATA;
            3'd2, 3'd3: begin
              if (!discard_q) begin
                state_d  = STALL;
                send_dec = 1'b1;
                clear    = (op_q[2:0] == 3'd2);
              end
            end
            3'd7:    clr_sticky = !discard_q;
            default: send_dec   = !discard_q;
          endcase
        end
      end
      DATA: begin
        if (data_last_byte) begin
          state_d = IDLE;
        end else if (timed_out) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end
      end
      STALL: begin
        if (cnt == STALL_LAST) state_d = ACC;
      end
      ACC: begin
        acc = 1'b1;
        if (cnt == ACC_LAST) state_d = SEND;
      end
      SEND: begin
        out = !busy && !out_q;
        if (out && (sel_q == SEL_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      op_q        <= '0;
      discard_q   <= 1'b0;
      unit_q      <= '0;
      dcnt        <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
      sel_q       <= '0;
      out_q       <= 1'b0;
      send_data_q <= 1'b0;
      tmo_q       <= 1'b0;
      bad_addr_q  <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      if (load_unit) unit_q <= data_in[UW-1:0];
      if ((state == IDLE) && in) discard_q <= addr_bad;
      if ((state == OPCODE) && in) op_q <= data_in;

      // Counts cycles since the last accepted byte; DECODE is included so a
      // missing first operand byte is measured from the opcode byte.
      if (in)
        idle_cnt <= IW'(1);
      else if ((state == OPCODE) || (state == DECODE) || (state == DATA))
        idle_cnt <= idle_cnt + 1'b1;

      if (state == DECODE)
        dcnt <= '0;
      else if ((state == DATA) && in)
        dcnt <= dcnt + 1'b1;

      send_data_q <= data_last_byte && !discard_q;

      // The DECODE cycle is the first stall cycle, so accumulate begins STALL_CYC after send.
      if ((state == DECODE) || ((state == STALL) && (cnt == STALL_LAST)))
        cnt <= '0;
      else if ((state == STALL) || (state == ACC))
        cnt <= cnt + 1'b1;

      if (out) sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      out_q <= out;

      if (clr_sticky) begin
        tmo_q      <= 1'b0;
        bad_addr_q <= 1'b0;
        bad_op_q   <= 1'b0;
      end else begin
        if (set_tmo)      tmo_q      <= 1'b1;
        if (set_bad_addr) bad_addr_q <= 1'b1;
        if (set_bad_op)   bad_op_q   <= 1'b1;
      end
    end
  end

  assign get    = in;
  assign send   = send_dec | send_data_q;
  assign unit   = unit_q;
  assign sel    = sel_q;
  assign status = {tmo_q, bad_addr_q, bad_op_q, 2'b00, (state != IDLE), 2'b00};

endmodule

// File: tb/tb_ctrl_multi.sv
// tb/tb_ctrl_multi.sv - scoreboard bench for ctrl_multi
// Expected events are queued with their cycle; a negedge monitor pops and compares them.
module tb_ctrl_multi;

  localparam int EV_SEND    = 0;
  localparam int EV_OUT     = 1;
  localparam int EV_ACC_ON  = 2;
  localparam int EV_ACC_OFF = 3;
  localparam int EV_TMO     = 4;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] data_in;
  logic       in;
  logic       busy;
  logic       get, send, clear, acc, out;
  logic [1:0] unit;
  logic [3:0] sel;
  logic [7:0] status;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } evt_t;
  evt_t exp_q[$];

  ctrl_multi dut (
    .clk(clk), .nRst(nRst), .data_in(data_in), .in(in), .busy(busy),
    .get(get), .send(send), .unit(unit), .clear(clear), .acc(acc),
    .sel(sel), .out(out), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int kind, int val, int at);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endfunction

  function automatic void check_evt(int kind, int val);
    evt_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d (queue empty)", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        fails++;
        $display("FAIL event got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endfunction

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: fixed per-cycle order acc edges, send, out, tmo rise.
  logic acc_prev = 1'b0;
  logic tmo_prev = 1'b0;
  always @(negedge clk) begin
    if (acc && !acc_prev) check_evt(EV_ACC_ON, 0);
    if (!acc && acc_prev) check_evt(EV_ACC_OFF, 0);
    if (send) check_evt(EV_SEND, {29'd0, clear, unit});
    if (out) check_evt(EV_OUT, {28'd0, sel});
    if (status[7] && !tmo_prev) check_evt(EV_TMO, 0);
    if (get != in) check_evt(-1, {31'd0, get});
    acc_prev = acc;
    tmo_prev = status[7];
  end

  task automatic send_byte(input logic [7:0] b, output int t);
    @(posedge clk);
    #1 data_in = b;
    in = 1'b1;
    @(posedge clk);
    #1 in = 1'b0;
    t = cyc;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: %0d events still pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_acc"}, {31'd0, acc}, 0);
    check({name, "_out"}, {31'd0, out}, 0);
    check({name, "_send"}, {31'd0, send}, 0);
    check({name, "_clear"}, {31'd0, clear}, 0);
    check({name, "_sel"}, {28'd0, sel}, 0);
    check({name, "_unit"}, {30'd0, unit}, 0);
    check({name, "_status"}, {24'd0, status}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    nRst = 1'b0; in = 1'b0; busy = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    nRst = 1'b1;

    // 1: data command to unit 2, send one cycle after the 4th operand byte
    send_byte(8'h02, t);
    send_byte(8'h00, t);
    send_byte(8'hAA, t);
    send_byte(8'hBB, t);
    send_byte(8'hCC, t);
    send_byte(8'hDD, t);
    push(EV_SEND, 2, t);
    drain("t1", 20);
    @(posedge clk); #1;
    check("t1_unit", {30'd0, unit}, 2);
    check("t1_status", {24'd0, status}, 8'h00);

    // 2: OUT_RES on unit 1, full readout with busy low
    send_byte(8'h01, t);
    send_byte(8'h02, t);
    push(EV_SEND, 5, t);
    push(EV_ACC_ON, 0, t + 17);
    push(EV_ACC_OFF, 0, t + 145);
    for (int k = 0; k < 16; k++) push(EV_OUT, k, t + 145 + 2 * k);
    drain("t2", 400);
    wait_cyc(t + 176);
    check("t2_status_idle", {24'd0, status}, 8'h00);

    // 3: OUT_RES_ADD, busy held 50 cycles after the 4th byte
    send_byte(8'h01, t);
    send_byte(8'h03, t);
    push(EV_SEND, 1, t);
    push(EV_ACC_ON, 0, t + 17);
    push(EV_ACC_OFF, 0, t + 145);
    for (int k = 0; k < 4; k++) push(EV_OUT, k, t + 145 + 2 * k);
    for (int k = 4; k < 16; k++) push(EV_OUT, k, t + 202 + 2 * (k - 4));
    wait_cyc(t + 152);
    busy = 1'b1;
    wait_cyc(t + 180);
    check("t3_sel_frozen", {28'd0, sel}, 4);
    check("t3_busy_flag", {24'd0, status}, 8'h04);
    wait_cyc(t + 202);
    busy = 1'b0;
    drain("t3", 400);
    wait_cyc(t + 225);
    check("t3_status_idle", {24'd0, status}, 8'h00);

    // 4: bad address, bad opcode, then clear status
    send_byte(8'h05, t);
    send_byte(8'h05, t);
    wait_cyc(t + 1);
    check("t4_bad_addr", {24'd0, status}, 8'h40);
    send_byte(8'h00, t);
    send_byte(8'h09, t);
    wait_cyc(t + 1);
    check("t4_bad_op", {24'd0, status}, 8'h60);
    send_byte(8'h00, t);
    send_byte(8'h07, t);
    wait_cyc(t + 1);
    check("t4_clr_status", {24'd0, status}, 8'h00);

    // 5: timeout mid DATA, then a normal command
    send_byte(8'h00, t);
    send_byte(8'h00, t);
    send_byte(8'h11, t);
    push(EV_TMO, 0, t + 1022);
    drain("t5_tmo", 1100);
    check("t5_status_tmo", {24'd0, status}, 8'h80);
    send_byte(8'h00, t);
    send_byte(8'h00, t);
    for (int k = 0; k < 4; k++) send_byte(8'(k + 1), t);
    push(EV_SEND, 0, t);
    drain("t5_data", 20);
    send_byte(8'h00, t);
    send_byte(8'h07, t);
    wait_cyc(t + 1);
    check("t5_clr_status", {24'd0, status}, 8'h00);

    // 6a: reset during ACC
    send_byte(8'h01, t);
    send_byte(8'h02, t);
    push(EV_SEND, 5, t);
    push(EV_ACC_ON, 0, t + 17);
    push(EV_ACC_OFF, 0, t + 51);
    wait_cyc(t + 50);
    nRst = 1'b0;
    wait_cyc(t + 51);
    check_idle_outputs("t6a");
    nRst = 1'b1;
    drain("t6a", 20);
    repeat (300) @(posedge clk);
    #1;

    // 6b: reset during SEND after two bytes
    send_byte(8'h01, t);
    send_byte(8'h03, t);
    push(EV_SEND, 1, t);
    push(EV_ACC_ON, 0, t + 17);
    push(EV_ACC_OFF, 0, t + 145);
    push(EV_OUT, 0, t + 145);
    push(EV_OUT, 1, t + 147);
    wait_cyc(t + 148);
    nRst = 1'b0;
    wait_cyc(t + 149);
    check_idle_outputs("t6b");
    nRst = 1'b1;
    drain("t6b", 20);
    repeat (100) @(posedge clk);
    #1;
    check("t6b_quiet_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
